// File: rtl/v_mux_scan_serializer_if.sv
// Handshake and mux-side bus of the mux scan serializer.
// The master drives load/din/en and returns mux_do; the slave is the serializer.
interface v_mux_scan_serializer_if;
  logic       load;
  logic [7:0] din;
  logic       en;
  logic       mux_do;
  logic [7:0] di;
  logic [2:0] sel;
  logic       sout;
  logic       sout_valid;
  logic       busy;
  logic       done;

  modport master (
    output load,
    output din,
    output en,
    output mux_do,
    input  di,
    input  sel,
    input  sout,
    input  sout_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  din,
    input  en,
    input  mux_do,
    output di,
    output sel,
    output sout,
    output sout_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/v_mux_scan_serializer.sv
// Serializes a captured byte by stepping an external 8:1 mux select
// and registering the returned bit, one bit per enabled cycle.
module v_mux_scan_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic C,
  input  logic CLR,
  v_mux_scan_serializer_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // sel=000 addresses di[7], so MSB-first starts at 0 and counts up
  localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd0 : 3'd7;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic [2:0] r_sel;
  logic [2:0] w_sel_nxt;
  logic [7:0] r_di;
  logic [7:0] w_di_nxt;
  logic       r_sout;
  logic       w_sout_nxt;
  logic       r_vld;
  logic       w_vld_nxt;
  logic       r_done;
  logic       w_done_nxt;

  logic       w_accept;
  logic       w_step;
  logic       w_last;
  logic [2:0] w_sel_step;

  assign w_accept = (r_state == IDLE) && bus.load;
  assign w_step   = (r_state == SCAN) && bus.en;
  assign w_last   = w_step && (r_cnt == 3'd7);

  // 3-bit wrap lands exactly on SEL_START after the eighth step
  assign w_sel_step = MSB_FIRST ? (r_sel + 3'd1) : (r_sel - 3'd1);

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (bus.load) w_state_nxt = SCAN;
      SCAN: if (w_last)   w_state_nxt = IDLE;
      default:            w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_di_nxt   = r_di;
    w_cnt_nxt  = r_cnt;
    w_sel_nxt  = r_sel;
    w_sout_nxt = r_sout;
    w_vld_nxt  = 1'b0;
    w_done_nxt = 1'b0;
    unique case (1'b1)
      w_accept: begin
        w_di_nxt  = bus.din;
        w_cnt_nxt = 3'd0;
        w_sel_nxt = SEL_START;
      end
      w_step: begin
        w_sout_nxt = bus.mux_do;
        w_vld_nxt  = 1'b1;
        w_sel_nxt  = w_sel_step;
        w_cnt_nxt  = r_cnt + 3'd1;
        w_done_nxt = w_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_di   <= 8'h00;
      r_cnt  <= 3'd0;
      r_sel  <= 3'd0;
      r_sout <= 1'b0;
      r_vld  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_di   <= w_di_nxt;
      r_cnt  <= w_cnt_nxt;
      r_sel  <= w_sel_nxt;
      r_sout <= w_sout_nxt;
      r_vld  <= w_vld_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign bus.di         = r_di;
  assign bus.sel        = r_sel;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_vld;
  assign bus.busy       = (r_state == SCAN);
  assign bus.done       = r_done;

endmodule

// File: tb/tb_v_mux_scan_serializer.sv
// Directed bench for the mux scan serializer, MSB-first and LSB-first
// instances, each closed through a behavioural 8:1 mux.
module tb_v_mux_scan_serializer;

  logic C;
  logic CLR;
  int   checks;
  int   errors;

  v_mux_scan_serializer_if m_if ();
  v_mux_scan_serializer_if l_if ();

  v_mux_scan_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .C   (C),
    .CLR (CLR),
    .bus (m_if.slave)
  );

  v_mux_scan_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .C   (C),
    .CLR (CLR),
    .bus (l_if.slave)
  );

  // mux: sel=000 -> di[7] ... sel=111 -> di[0]
  assign m_if.mux_do = m_if.di[3'd7 - m_if.sel];
  assign l_if.mux_do = l_if.di[3'd7 - l_if.sel];

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".di"}, {24'h0, m_if.di}, 32'h00);
    chk({tag, ".sel"}, {29'h0, m_if.sel}, 32'h0);
    chk({tag, ".sout"}, {31'h0, m_if.sout}, 32'h0);
    chk({tag, ".vld"}, {31'h0, m_if.sout_valid}, 32'h0);
    chk({tag, ".busy"}, {31'h0, m_if.busy}, 32'h0);
    chk({tag, ".done"}, {31'h0, m_if.done}, 32'h0);
  endtask

  // eight enabled edges on the MSB instance, expected bits MSB of exp first
  task automatic scan8(input string tag, input logic [7:0] exp,
                       input logic [7:0] exp_di);
    logic [7:0] e;
    e = exp;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk({tag, ".vld"}, {31'h0, m_if.sout_valid}, 32'h1);
      chk({tag, ".bit"}, {31'h0, m_if.sout}, {31'h0, e[7 - i]});
      chk({tag, ".done"}, {31'h0, m_if.done}, (i == 7) ? 32'h1 : 32'h0);
      chk({tag, ".busy"}, {31'h0, m_if.busy}, (i == 7) ? 32'h0 : 32'h1);
      chk({tag, ".sel"}, {29'h0, m_if.sel}, i + 1 & 7);
      chk({tag, ".di"}, {24'h0, m_if.di}, {24'h0, exp_di});
    end
  endtask

  initial begin
    logic [9:0]  en_pat;
    logic [7:0]  w;
    logic [7:0]  word;
    logic [7:0]  din_r;
    int          nb;
    int          bi;
    int          budget;
    checks = 0;
    errors = 0;
    CLR = 1'b1;
    m_if.load = 1'b0;
    m_if.din  = 8'h00;
    m_if.en   = 1'b0;
    l_if.load = 1'b0;
    l_if.din  = 8'h00;
    l_if.en   = 1'b0;
    tick();
    tick();
    chk_zero("rst");
    chk("rst.l_busy", {31'h0, l_if.busy}, 32'h0);
    chk("rst.l_sel", {29'h0, l_if.sel}, 32'h0);
    CLR = 1'b0;

    // MSB-first A5
    m_if.din  = 8'hA5;
    m_if.load = 1'b1;
    m_if.en   = 1'b1;
    tick();
    m_if.load = 1'b0;
    chk("a5.busy0", {31'h0, m_if.busy}, 32'h1);
    chk("a5.di0", {24'h0, m_if.di}, 32'hA5);
    chk("a5.sel0", {29'h0, m_if.sel}, 32'h0);
    chk("a5.vld0", {31'h0, m_if.sout_valid}, 32'h0);
    scan8("a5", 8'hA5, 8'hA5);
    tick();
    chk("a5.idle_vld", {31'h0, m_if.sout_valid}, 32'h0);
    chk("a5.idle_done", {31'h0, m_if.done}, 32'h0);
    chk("a5.idle_di", {24'h0, m_if.di}, 32'hA5);

    // LSB-first 01
    l_if.din  = 8'h01;
    l_if.load = 1'b1;
    l_if.en   = 1'b1;
    tick();
    l_if.load = 1'b0;
    chk("l01.sel0", {29'h0, l_if.sel}, 32'h7);
    w = 8'h01;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("l01.vld", {31'h0, l_if.sout_valid}, 32'h1);
      chk("l01.bit", {31'h0, l_if.sout}, {31'h0, w[i]});
      chk("l01.sel", {29'h0, l_if.sel}, (7 - (i + 1)) & 7);
      chk("l01.done", {31'h0, l_if.done}, (i == 7) ? 32'h1 : 32'h0);
    end
    l_if.en = 1'b0;
    tick();
    chk("l01.end_busy", {31'h0, l_if.busy}, 32'h0);

    // F0 with stalls on scan cycles 3 and 6
    m_if.din  = 8'hF0;
    m_if.load = 1'b1;
    tick();
    m_if.load = 1'b0;
    en_pat = 10'b11_1101_1011;
    w = 8'hF0;
    bi = 0;
    for (int k = 0; k < 10; k++) begin
      m_if.en = en_pat[k];
      tick();
      chk("f0.vld", {31'h0, m_if.sout_valid}, {31'h0, en_pat[k]});
      if (en_pat[k]) begin
        chk("f0.bit", {31'h0, m_if.sout}, {31'h0, w[7 - bi]});
        bi++;
      end
      chk("f0.done", {31'h0, m_if.done}, (k == 9) ? 32'h1 : 32'h0);
      chk("f0.busy", {31'h0, m_if.busy}, (k == 9) ? 32'h0 : 32'h1);
    end
    m_if.en = 1'b1;

    // load held through a scan, back-to-back capture at done
    m_if.din  = 8'hC3;
    m_if.load = 1'b1;
    tick();
    m_if.din = 8'h00;
    scan8("c3", 8'hC3, 8'hC3);
    tick();
    m_if.load = 1'b0;
    chk("b2b.busy", {31'h0, m_if.busy}, 32'h1);
    chk("b2b.di", {24'h0, m_if.di}, 32'h00);
    scan8("z0", 8'h00, 8'h00);

    // CLR after the 4th bit of FF
    m_if.din  = 8'hFF;
    m_if.load = 1'b1;
    tick();
    m_if.load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ff.vld4", {31'h0, m_if.sout_valid}, 32'h1);
    chk("ff.sout4", {31'h0, m_if.sout}, 32'h1);
    #2;
    CLR = 1'b1;
    #1;
    chk_zero("aclr");
    tick();
    chk_zero("aclr_hold");
    CLR = 1'b0;
    m_if.din  = 8'h0F;
    m_if.load = 1'b1;
    tick();
    m_if.load = 1'b0;
    chk("postclr.busy", {31'h0, m_if.busy}, 32'h1);
    scan8("0f", 8'h0F, 8'h0F);

    // random words and stalls through a bit collector
    for (int s = 0; s < 40; s++) begin
      din_r     = 8'($urandom);
      m_if.din  = din_r;
      m_if.load = 1'b1;
      m_if.en   = 1'b1;
      tick();
      m_if.load = 1'b0;
      word   = 8'h00;
      nb     = 0;
      budget = 0;
      while (!m_if.done && budget < 200) begin
        m_if.en = ($urandom_range(0, 3) != 0);
        tick();
        budget++;
        if (m_if.sout_valid) begin
          word = {word[6:0], m_if.sout};
          nb++;
        end
        if (m_if.done && !m_if.sout_valid) begin
          chk("rnd.done_wo_vld", 32'h1, 32'h0);
        end
      end
      chk("rnd.timeout", {31'h0, m_if.done}, 32'h1);
      chk("rnd.count", nb, 8);
      chk("rnd.word", {24'h0, word}, {24'h0, din_r});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_mux_scan_serializer.md
V_MUX_SCAN_SERIALIZER -- requirements
Module: v_mux_scan_serializer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 = scan di[7] first, 0 = scan di[0] first.
REQ-002 SHALL have port C  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port CLR  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port load  input  1  request to capture din and start a scan; sampled only when busy=0.
REQ-005 SHALL have port din  input  8  parallel word to serialize.
REQ-006 SHALL have port en  input  1  advance enable; 0 stalls the scan.
REQ-007 SHALL have port mux_do  input  1  bit returned by the downstream 8:1 mux for the current di/sel.
REQ-008 SHALL have port di  output  8  registered word driven to the mux data input.
REQ-009 SHALL have port sel  output  3  registered select driven to the mux; mux mapping is sel=000 -> di[7] ... sel=111 -> di[0].
REQ-010 SHALL have port sout  output  1  registered serial bit.
REQ-011 SHALL have port sout_valid  output  1  sout holds a new bit this cycle.
REQ-012 SHALL have port busy  output  1  scan in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse with the eighth sout_valid.

Function
REQ-014 SHALL implement two states, IDLE and SCAN, plus a 3-bit bit counter cnt.
REQ-015 In IDLE with load=1, the next edge SHALL set di=din, cnt=0, and state=SCAN.
- That edge SHALL also set sel=000 if MSB_FIRST=1, or sel=111 if MSB_FIRST=0.
REQ-016 In IDLE with load=0, di and sel SHALL hold and sout_valid SHALL be 0.
REQ-017 In SCAN with en=1, each edge SHALL register sout=mux_do and set sout_valid=1 for the following cycle.
- The same edge SHALL step sel by +1 (MSB_FIRST=1) or -1 (MSB_FIRST=0) and increment cnt.
REQ-018 Latency: the bit selected by sel in cycle k SHALL appear on sout in cycle k+1.
REQ-019 In SCAN with en=0, sel, cnt, di and sout SHALL hold, and sout_valid SHALL be 0 the next cycle.
REQ-020 When cnt=7 and en=1 in SCAN, the edge SHALL capture the last bit, set done=1 together with sout_valid=1 for one cycle, and return to IDLE.
- sel SHALL wrap to its start value on this edge, with no out-of-range step.
REQ-021 busy SHALL be 1 exactly while state=SCAN.
REQ-022 load SHALL be ignored while busy=1; di SHALL NOT change during a scan.
REQ-023 load=1 in the cycle where done=1 (state already IDLE) SHALL be accepted, giving back-to-back scans with no idle bit slot.
REQ-024 Exactly eight sout_valid pulses SHALL occur per accepted load, regardless of en stalls.
REQ-025 done SHALL never assert without sout_valid.

Reset
REQ-026 CLR=1 SHALL immediately force state=IDLE, cnt=0, di=8'h00, sel=3'b000, sout=0, sout_valid=0, busy=0 and done=0, independent of C.
REQ-027 CLR asserted mid-scan SHALL abort the scan with no done pulse.
- After CLR deasserts, the block SHALL wait in IDLE for a new load.
REQ-028 load sampled on the first edge after CLR deasserts SHALL be honoured normally.

Verification
REQ-029 MSB_FIRST=1, din=8'hA5, load pulse, en=1 with the mux model connected -> sout bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; done with the 8th; busy high for 8 cycles.
REQ-030 MSB_FIRST=0, din=8'h01 -> first sout=1 and the remaining seven bits 0; sel sequence 7,6,5,...,0.
REQ-031 din=8'hF0, en low on cycles 3 and 6 of the scan -> same 8-bit sequence 1,1,1,1,0,0,0,0; sout_valid gaps at the stalls; scan spans 10 cycles.
REQ-032 load held high during a scan with din changed to 8'h00 -> di stays at the original word; the new word is captured only when done=1; second scan follows immediately.
REQ-033 CLR asserted after the 4th bit of din=8'hFF -> all outputs zero asynchronously, no done; next load of 8'h0F yields 0,0,0,0,1,1,1,1.
REQ-034 Random din/load/en/CLR for at least 10k cycles against a reference model -> every completed scan reproduces din in MSB_FIRST order with exactly 8 valid bits.
